// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN weight-update datapath: FSM state encoding
// and a constant-foldable ceiling-log2 helper.
package dqn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } upd_state_e;

  // Ceiling log2; returns 0 for 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v != 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/update_weight_addr_gen.sv
// Walks one layer's weight matrix (forward node outer, back node + bias inner)
// and presents the registered address/bias/last payload of the current request.
module update_weight_addr_gen
  import dqn_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     advance,
  input  logic [7:0]               f_count,
  input  logic [7:0]               b_count,
  output logic [ADDRESS_WIDTH-1:0] weight_addr,
  output logic [ADDRESS_WIDTH-1:0] data_addr,
  output logic [ADDRESS_WIDTH-1:0] delta_addr,
  output logic                     bias,
  output logic                     last
);

  logic [7:0]               f_q, b_q, f_n, b_n;
  logic [ADDRESS_WIDTH-1:0] w_n;
  logic                     bias_n, last_n;

  // Next position: b runs 0..B where B is the bias slot, then f advances.
  always_comb begin
    f_n = f_q;
    b_n = b_q;
    w_n = weight_addr;
    if (load) begin
      f_n = '0;
      b_n = '0;
      w_n = '0;
    end else if (advance) begin
      if (b_q == b_count) begin
        b_n = '0;
        f_n = f_q + 8'd1;
      end else begin
        b_n = b_q + 8'd1;
      end
      w_n = weight_addr + ADDRESS_WIDTH'(1);
    end
    bias_n = (b_n == b_count);
    last_n = bias_n && (f_n == 8'(f_count - 8'd1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q         <= '0;
      b_q         <= '0;
      weight_addr <= '0;
      data_addr   <= '0;
      delta_addr  <= '0;
      bias        <= 1'b0;
      last        <= 1'b0;
    end else if (load || advance) begin
      f_q         <= f_n;
      b_q         <= b_n;
      weight_addr <= w_n;
      data_addr   <= bias_n ? '0 : ADDRESS_WIDTH'(b_n);
      delta_addr  <= ADDRESS_WIDTH'(f_n);
      bias        <= bias_n;
      last        <= last_n;
    end
  end

endmodule

// File: rtl/update_weight_sequencer.sv
// Issues weight-update requests layer by layer (highest first), limiting the
// number of unacknowledged requests and draining each layer before the next.
module update_weight_sequencer
  import dqn_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH   = 11,
  parameter int unsigned NUM_LAYERS      = 3,
  parameter logic [8*(NUM_LAYERS+1)-1:0] NODE_COUNTS = {8'd3, 8'd32, 8'd32, 8'd2},
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [NUM_LAYERS-1:0]    i_layer_mask,
  output logic                     o_req_valid,
  input  logic                     i_req_ready,
  output logic [1:0]               o_req_layer,
  output logic [ADDRESS_WIDTH-1:0] o_weight_addr,
  output logic [ADDRESS_WIDTH-1:0] o_data_addr,
  output logic [ADDRESS_WIDTH-1:0] o_delta_addr,
  output logic                     o_req_bias,
  output logic                     o_req_last,
  input  logic                     i_resp_valid,
  output logic                     o_busy,
  output logic                     o_valid
);

  localparam int unsigned      OUT_W   = clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  upd_state_e            state_q, state_d;
  logic [1:0]            layer_q, layer_d;
  logic [NUM_LAYERS-1:0] mask_q, mask_d;
  logic [OUT_W-1:0]      outst_q, outst_d;
  logic                  req_valid_d, busy_d, valid_d;
  logic                  xfer, resp, load;
  logic                  cur_en, lower_en;
  logic [7:0]            f_cnt, b_cnt;

  assign o_req_layer = layer_q;
  assign xfer        = o_req_valid && i_req_ready;
  assign resp        = i_resp_valid && (outst_q != '0);

  // Per-layer node counts and enable bits for the layer currently selected.
  always_comb begin
    cur_en   = 1'b0;
    lower_en = 1'b0;
    f_cnt    = '0;
    b_cnt    = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (layer_q == 2'(l)) begin
        cur_en = mask_q[l];
        f_cnt  = NODE_COUNTS[8*(l+1) +: 8];
        b_cnt  = NODE_COUNTS[8*l +: 8];
      end
      if ((2'(l) < layer_q) && mask_q[l]) lower_en = 1'b1;
    end
  end

  always_comb begin
    outst_d = outst_q;
    if (xfer && !resp) outst_d = outst_q + OUT_W'(1);
    else if (!xfer && resp) outst_d = outst_q - OUT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    mask_d      = mask_q;
    load        = 1'b0;
    req_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          state_d = ST_SELECT;
          mask_d  = i_layer_mask;
          layer_d = 2'(NUM_LAYERS - 1);
        end
      end
      ST_SELECT: begin
        if (cur_en) begin
          state_d     = ST_ISSUE;
          load        = 1'b1;
          req_valid_d = (outst_d < OUT_MAX);
        end else if (lower_en) begin
          layer_d = layer_q - 2'd1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (xfer && o_req_last) state_d = ST_DRAIN;
        else req_valid_d = (outst_d < OUT_MAX);
      end
      ST_DRAIN: begin
        // Layers never overlap: the next one starts only once all responses are back.
        if (outst_q == '0) begin
          if (layer_q == 2'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SELECT;
            layer_d = layer_q - 2'd1;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      layer_q     <= '0;
      mask_q      <= '0;
      outst_q     <= '0;
      o_req_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_valid     <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      mask_q      <= mask_d;
      outst_q     <= outst_d;
      o_req_valid <= req_valid_d;
      o_busy      <= busy_d;
      o_valid     <= valid_d;
    end
  end

  update_weight_addr_gen #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .advance    (xfer),
    .f_count    (f_cnt),
    .b_count    (b_cnt),
    .weight_addr(o_weight_addr),
    .data_addr  (o_data_addr),
    .delta_addr (o_delta_addr),
    .bias       (o_req_bias),
    .last       (o_req_last)
  );

endmodule

// File: tb/tb_update_weight_sequencer.sv
// Bench for update_weight_sequencer: directed steps with randomized handshakes,
// checked against a request-list model built from the layer geometry.
module tb_update_weight_sequencer;

  localparam int unsigned AW   = 11;
  localparam int unsigned NL   = 2;
  localparam int unsigned MAXO = 2;
  localparam logic [23:0] NC   = {8'd2, 8'd3, 8'd2};

  typedef struct packed {
    logic [1:0]    layer;
    logic [AW-1:0] w;
    logic [AW-1:0] data;
    logic [AW-1:0] delta;
    logic          bias;
    logic          last;
  } req_t;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic [NL-1:0] i_layer_mask;
  logic          o_req_valid;
  logic          i_req_ready;
  logic [1:0]    o_req_layer;
  logic [AW-1:0] o_weight_addr, o_data_addr, o_delta_addr;
  logic          o_req_bias, o_req_last;
  logic          i_resp_valid;
  logic          o_busy, o_valid;

  int   checks = 0;
  int   errors = 0;
  int   nodes [3] = '{2, 3, 2};
  req_t exp_q [$];

  update_weight_sequencer #(
    .ADDRESS_WIDTH(AW), .NUM_LAYERS(NL), .NODE_COUNTS(NC), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_layer_mask(i_layer_mask),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_layer(o_req_layer),
    .o_weight_addr(o_weight_addr), .o_data_addr(o_data_addr), .o_delta_addr(o_delta_addr),
    .o_req_bias(o_req_bias), .o_req_last(o_req_last), .i_resp_valid(i_resp_valid),
    .o_busy(o_busy), .o_valid(o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t cur_req();
    req_t r;
    r.layer = o_req_layer;
    r.w     = o_weight_addr;
    r.data  = o_data_addr;
    r.delta = o_delta_addr;
    r.bias  = o_req_bias;
    r.last  = o_req_last;
    return r;
  endfunction

  // Expected request list: layers high to low, f outer, b inner with bias slot at b==B.
  task automatic build(input logic [NL-1:0] mask);
    req_t e;
    exp_q.delete();
    for (int l = NL - 1; l >= 0; l--) begin
      if (mask[l]) begin
        for (int f = 0; f < nodes[l+1]; f++) begin
          for (int b = 0; b <= nodes[l]; b++) begin
            e.layer = 2'(l);
            e.w     = AW'(f * (nodes[l] + 1) + b);
            e.data  = (b == nodes[l]) ? '0 : AW'(b);
            e.delta = AW'(f);
            e.bias  = (b == nodes[l]);
            e.last  = (f == nodes[l+1] - 1) && (b == nodes[l]);
            exp_q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_valid"}, o_req_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_payload"}, cur_req(), 0);
  endtask

  // One start pulse; rdy_mode 0=always 1=toggle 2=random, rsp_mode 0=next cycle 1=random 2=withheld.
  task automatic run_seq(input logic [NL-1:0] mask, input int rdy_mode, input int rsp_mode,
                         output int first_n, output int done_n, output int xfers, output int total);
    int   out;
    bit   in_layer, prev_stall, prev_xfer, seen_done, finished, xfer, resp;
    req_t prev_req, now_req, e;
    build(mask);
    total = exp_q.size();
    out = 0; in_layer = 0; prev_stall = 0; prev_xfer = 0; seen_done = 0; finished = 0;
    prev_req = '0; first_n = -1; done_n = -1; xfers = 0;
    i_valid = 1'b1; i_layer_mask = mask; i_req_ready = 1'b0; i_resp_valid = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      // A second start while busy must be ignored.
      i_valid = (n == 1);
      if (n == 1) i_layer_mask = NL'($urandom);
      else i_valid = 1'b0;
      now_req = cur_req();
      if (seen_done) begin
        chk("idle_busy", o_busy, 0);
        chk("idle_valid", o_valid, 0);
        i_req_ready = 1'b0; i_resp_valid = 1'b0;
        finished = 1;
        break;
      end
      chk("busy", o_busy, 1);
      if (o_valid) begin
        seen_done = 1; done_n = n;
        chk("done_queue_left", exp_q.size(), 0);
        chk("done_outstanding", out, 0);
      end
      if (o_req_valid && first_n < 0) first_n = n;
      if (in_layer) chk("valid_vs_outstanding", o_req_valid, out < MAXO);
      else if (o_req_valid) in_layer = 1;
      if (prev_stall && o_req_valid) chk("payload_stable", now_req, prev_req);
      if (rsp_mode == 2 && n == 19) chk("withheld_transfers", xfers, 2);
      case (rdy_mode)
        0:       i_req_ready = 1'b1;
        1:       i_req_ready = n[0];
        default: i_req_ready = 1'($urandom);
      endcase
      case (rsp_mode)
        0:       i_resp_valid = prev_xfer;
        1:       i_resp_valid = ($urandom_range(0, 99) < 50);
        default: i_resp_valid = (n >= 20) && ($urandom_range(0, 99) < 50);
      endcase
      xfer = o_req_valid && i_req_ready;
      resp = i_resp_valid && (out > 0);
      prev_stall = o_req_valid && !i_req_ready;
      prev_req = now_req;
      if (xfer) begin
        xfers++;
        if (exp_q.size() == 0) chk("extra_request", xfers, total);
        else begin
          e = exp_q.pop_front();
          chk("request", now_req, e);
          if (e.w == '0) chk("layer_start_outstanding", out, 0);
          if (e.last) in_layer = 0;
        end
      end
      out = out + int'(xfer) - int'(resp);
      prev_xfer = xfer;
    end
    chk("sequence_finished", finished, 1);
  endtask

  initial begin
    int fn, dn, xf, tot, cnt, pv;
    bit hit;
    logic [NL-1:0] m;
    rst = 1'b1; i_valid = 1'b0; i_layer_mask = '0; i_req_ready = 1'b0; i_resp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    chk("reset_layer", o_req_layer, 0);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Both layers, full-rate ready, responses one cycle after transfer.
    run_seq(2'b11, 0, 0, fn, dn, xf, tot);
    chk("m11_first_req_latency", fn, 2);
    chk("m11_transfers", xf, 17);

    // Layer 0 only.
    run_seq(2'b01, 0, 0, fn, dn, xf, tot);
    chk("m01_transfers", xf, 9);
    chk("m01_first_req_latency", fn, 3);

    // Responses withheld: issue stalls at the outstanding limit.
    run_seq(2'b11, 0, 2, fn, dn, xf, tot);
    chk("withheld_total", xf, 17);

    // Toggling ready with random responses (incl. simultaneous transfer/response).
    run_seq(2'b11, 1, 1, fn, dn, xf, tot);
    chk("toggle_total", xf, 17);

    // Reset while the fifth layer-1 request is presented.
    cnt = 0; pv = 0; hit = 0;
    @(negedge clk);
    i_valid = 1'b1; i_layer_mask = 2'b11; i_req_ready = 1'b1; i_resp_valid = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge clk);
      i_valid = 1'b0;
      if (o_req_valid && cnt == 4) hit = 1;
      else begin
        i_resp_valid = pv[0];
        pv = int'(o_req_valid);
        if (o_req_valid) cnt++;
      end
    end
    chk("reached_fifth_request", hit, 1);
    chk("fifth_weight_addr", o_weight_addr, 4);
    chk("fifth_layer", o_req_layer, 1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    chk("mid_reset_layer", o_req_layer, 0);
    i_req_ready = 1'b0; i_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("after_reset_no_valid", o_valid, 0);
      chk("after_reset_no_req", o_req_valid, 0);
    end
    run_seq(2'b11, 0, 0, fn, dn, xf, tot);
    chk("restart_transfers", xf, 17);

    // Empty mask: completion two cycles after start, no requests.
    run_seq(2'b00, 0, 0, fn, dn, xf, tot);
    chk("m00_done_latency", dn, 2);
    chk("m00_no_request", fn, -1);
    chk("m00_transfers", xf, 0);

    // Random masks with random handshakes.
    for (int k = 0; k < 6; k++) begin
      m = NL'($urandom);
      run_seq(m, 2, 1, fn, dn, xf, tot);
      chk("random_transfers", xf, tot);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/update_weight_sequencer.md
UPDATE_WEIGHT_SEQUENCER -- requirements
Module: update_weight_sequencer

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 11, width of all address outputs.
REQ-002 Parameter NUM_LAYERS, default 3, number of weight layers, range 1..4.
REQ-003 Parameter NODE_COUNTS, default {8'd3,8'd32,8'd32,8'd2}, packed 8-bit node counts; field 0 (LSB) is input nodes, field NUM_LAYERS is output nodes.
REQ-004 Parameter MAX_OUTSTANDING, default 4, maximum issued-but-unacknowledged requests, range 1..15.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 i_valid  input  1  start pulse.
REQ-008 i_layer_mask  input  NUM_LAYERS  per-layer update enable, sampled with i_valid.
REQ-009 o_req_valid  output  1  update request valid.
REQ-010 i_req_ready  input  1  engine accepts request.
REQ-011 o_req_layer  output  2  layer index of request.
REQ-012 o_weight_addr  output  ADDRESS_WIDTH  weight word address within layer.
REQ-013 o_data_addr  output  ADDRESS_WIDTH  data-point address (back node index).
REQ-014 o_delta_addr  output  ADDRESS_WIDTH  delta address (forward node index).
REQ-015 o_req_bias  output  1  request is the bias term (no data point; engine uses 1.0).
REQ-016 o_req_last  output  1  last request of current layer.
REQ-017 i_resp_valid  input  1  one-cycle pulse: one new weight written back.
REQ-018 o_busy  output  1  sequence in progress.
REQ-019 o_valid  output  1  one-cycle pulse: all enabled layers updated.

Function
REQ-020 Layer l has F=NODE_COUNTS[l+1] forward nodes and B=NODE_COUNTS[l] back nodes; it needs F*(B+1) requests.
REQ-021 Layers SHALL be processed in descending order NUM_LAYERS-1 down to 0; layers with mask bit 0 SHALL be skipped with zero requests.
REQ-022 Within a layer, order is f outer 0..F-1, b inner 0..B; o_weight_addr=f*(B+1)+b, o_delta_addr=f, o_data_addr=b (0 when bias), o_req_bias=(b==B).
REQ-023 A request transfers when o_req_valid and i_req_ready are both high at a rising edge; payload SHALL be stable while o_req_valid is high and not yet accepted.
REQ-024 o_req_valid SHALL be low while outstanding count equals MAX_OUTSTANDING.
REQ-025 Outstanding count: +1 on transfer, -1 on i_resp_valid, unchanged when both occur in the same cycle; i_resp_valid at count 0 SHALL be ignored.
REQ-026 States: IDLE, SELECT, ISSUE, DRAIN, DONE.
REQ-027 IDLE->SELECT on i_valid; mask and layer index latched; o_busy high from next cycle until return to IDLE.
REQ-028 SELECT: enabled layer -> ISSUE; disabled -> next lower layer in the next cycle; past layer 0 -> DONE.
REQ-029 ISSUE->DRAIN after transfer of the request with o_req_last high.
REQ-030 DRAIN waits for outstanding count 0, then -> SELECT for the next lower layer (no overlap between layers).
REQ-031 DONE asserts o_valid for exactly one cycle and returns to IDLE.
REQ-032 i_valid while o_busy is high SHALL be ignored; an all-zero mask SHALL produce o_valid two cycles after i_valid with no requests.
REQ-033 Start-to-first-request latency: o_req_valid high two cycles after the i_valid edge.

Reset
REQ-034 rst SHALL force IDLE, clear counters and outstanding count, and drive o_req_valid, o_busy, o_valid, o_req_last, o_req_bias low and all addresses and o_req_layer to 0, including mid-sequence; no o_valid follows.

Structure
REQ-035 State encodings and a clog2 function SHALL reside in shared package file dqn_pkg; NODE_COUNTS field extraction is local.
REQ-036 One sub-module, update_weight_addr_gen (f/b counters, address and last/bias generation), SHALL be instantiated; FSM and outstanding counter stay in the top.

Verification (NUM_LAYERS=2, NODE_COUNTS={8'd2,8'd3,8'd2}, MAX_OUTSTANDING=2)
REQ-037 Mask 2'b11, ready always 1, response 1 cycle after each transfer -> 8 layer-1 requests then 9 layer-0 requests, last addresses 7 and 8, one o_valid.
REQ-038 Mask 2'b01 -> only 9 layer-0 requests, o_req_layer=0 throughout, o_valid once.
REQ-039 Responses withheld -> exactly 2 transfers, o_req_valid low until a response arrives, payload stable.
REQ-040 i_req_ready toggling each cycle plus simultaneous transfer/response -> count unchanged, no lost or duplicate address.
REQ-041 rst asserted at 5th request of layer 1 -> all outputs 0 immediately; new i_valid restarts at address 0.
REQ-042 Mask 2'b00 -> o_valid two cycles after i_valid, no o_req_valid; i_valid while busy ignored.
